// File: rtl/ssd_pkg.sv
// Shared definitions for the seven/fourteen-segment scan engine:
// anode-off level, slot state encoding and counter-width helper.
package ssd_pkg;

  localparam logic ANODE_OFF = 1'b1;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2
  } slot_state_e;

  function automatic int clog2_min1(input int value);
    if (value <= 2) begin
      return 1;
    end else begin
      return $clog2(value);
    end
  endfunction

endpackage

// File: rtl/ssd_scan_engine_if.sv
// Value/control bus between digit logic (master) and the scan engine (slave).
interface ssd_scan_engine_if
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 4,
  parameter int DUTY_W     = 4
);
  localparam int IDX_W = clog2_min1(NUM_DIGITS);

  logic [NUM_DIGITS*DATA_W-1:0] digits_in;
  logic                         load;
  logic [NUM_DIGITS-1:0]        digit_en;
  logic [DUTY_W-1:0]            brightness;
  logic [NUM_DIGITS-1:0]        ssd_ctl;
  logic [DATA_W-1:0]            ssd_in;
  logic [IDX_W-1:0]             digit_idx;
  logic                         frame_done;

  modport master (
    output digits_in, load, digit_en, brightness,
    input  ssd_ctl, ssd_in, digit_idx, frame_done
  );

  modport slave (
    input  digits_in, load, digit_en, brightness,
    output ssd_ctl, ssd_in, digit_idx, frame_done
  );
endinterface

// File: rtl/ssd_slot_timer.sv
// Prescale counter for one digit slot; exposes the upcoming slot cycle so the
// top level can register its outputs one cycle ahead.
module ssd_slot_timer
  import ssd_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = clog2_min1(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             slot_start,
  output logic             slot_last,
  output logic [CNT_W-1:0] cycle_next
);
  logic [CNT_W-1:0] cnt_r;

  assign slot_start = (cnt_r == {CNT_W{1'b0}});
  assign slot_last  = (cnt_r == CNT_W'(PRESCALE - 1));

  // wrap at the end of the slot
  always_comb begin
    cycle_next = cnt_r + CNT_W'(32'd1);
    if (slot_last) begin
      cycle_next = {CNT_W{1'b0}};
    end else begin
      cycle_next = cnt_r + CNT_W'(32'd1);
    end
  end

  // slot cycle register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cycle_next;
    end
  end
endmodule

// File: rtl/ssd_scan_engine.sv
// Time-multiplexed digit scanner: slot FSM with dead-time and PWM on-time,
// double-buffered frame data swapped only at the frame boundary.
module ssd_scan_engine
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DATA_W       = 4,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 8,
  parameter int DUTY_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ssd_scan_engine_if.slave  bus
);
  localparam int IDX_W = clog2_min1(NUM_DIGITS);
  localparam int CNT_W = clog2_min1(PRESCALE);
  localparam int STEP  = (PRESCALE - BLANK_CYCLES) >> DUTY_W;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF  = {NUM_DIGITS{ANODE_OFF}};
  localparam int FW = NUM_DIGITS * DATA_W;

  logic              slot_start, slot_last, boundary;
  logic [CNT_W-1:0]  cycle_next;
  logic [IDX_W-1:0]  idx_r, idx_next;
  logic [FW-1:0]     active_r, active_next, pending_r;
  logic              pend_r;
  logic [DUTY_W-1:0] bright_r, bright_sel;
  logic [31:0]       on_end, cyc_ext;
  logic              in_blank, in_on;
  slot_state_e       state_r, state_next;
  logic [NUM_DIGITS-1:0] ctl_r, ctl_next;
  logic [DATA_W-1:0] ssd_in_r;
  logic              frame_done_r;

  ssd_slot_timer #(.PRESCALE(PRESCALE), .CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_start (slot_start),
    .slot_last  (slot_last),
    .cycle_next (cycle_next)
  );

  assign boundary = slot_last && (idx_r == {IDX_W{1'b0}});

  // scan order runs downward and wraps to the top digit
  always_comb begin
    idx_next = idx_r;
    if (slot_last) begin
      if (idx_r == {IDX_W{1'b0}}) begin
        idx_next = LAST_IDX;
      end else begin
        idx_next = idx_r - IDX_W'(32'd1);
      end
    end else begin
      idx_next = idx_r;
    end
  end

  // a load on the boundary cycle wins over any pending frame
  always_comb begin
    active_next = active_r;
    if (boundary) begin
      if (bus.load) begin
        active_next = bus.digits_in;
      end else if (pend_r) begin
        active_next = pending_r;
      end else begin
        active_next = active_r;
      end
    end else begin
      active_next = active_r;
    end
  end

  // brightness is live only on slot cycle 0, then held for the slot
  always_comb begin
    bright_sel = slot_start ? bus.brightness : bright_r;
    on_end     = 32'(BLANK_CYCLES) + (32'(bright_sel) + 32'd1) * 32'(STEP);
    cyc_ext    = 32'(cycle_next);
    in_blank   = (cyc_ext < 32'(BLANK_CYCLES));
    in_on      = (cyc_ext < on_end) && bus.digit_en[idx_next];
  end

  // next-state logic of the slot FSM
  always_comb begin
    state_next = ST_BLANK;
    case (state_r)
      ST_BLANK: state_next = in_blank ? ST_BLANK : (in_on ? ST_ON : ST_OFF);
      ST_ON:    state_next = in_blank ? ST_BLANK : (in_on ? ST_ON : ST_OFF);
      ST_OFF:   state_next = in_blank ? ST_BLANK : (in_on ? ST_ON : ST_OFF);
      default:  state_next = ST_BLANK;
    endcase
  end

  // anode decode of the next state
  always_comb begin
    ctl_next = ALL_OFF;
    case (state_next)
      ST_ON:    ctl_next[idx_next] = 1'b0;
      ST_BLANK: ctl_next = ALL_OFF;
      ST_OFF:   ctl_next = ALL_OFF;
      default:  ctl_next = ALL_OFF;
    endcase
  end

  // state, output and frame-buffer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_BLANK;
      ctl_r        <= ALL_OFF;
      ssd_in_r     <= {DATA_W{1'b0}};
      idx_r        <= LAST_IDX;
      frame_done_r <= 1'b0;
      active_r     <= {FW{1'b0}};
      pending_r    <= {FW{1'b0}};
      pend_r       <= 1'b0;
      bright_r     <= {DUTY_W{1'b0}};
    end else begin
      state_r      <= state_next;
      ctl_r        <= ctl_next;
      ssd_in_r     <= active_next[idx_next*DATA_W +: DATA_W];
      idx_r        <= idx_next;
      frame_done_r <= boundary;
      active_r     <= active_next;
      if (slot_start) begin
        bright_r <= bus.brightness;
      end
      if (boundary) begin
        pend_r <= 1'b0;
      end else if (bus.load) begin
        pending_r <= bus.digits_in;
        pend_r    <= 1'b1;
      end
    end
  end

  assign bus.ssd_ctl    = ctl_r;
  assign bus.ssd_in     = ssd_in_r;
  assign bus.digit_idx  = idx_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_ssd_scan_engine.sv
// Bench for ssd_scan_engine (N=4, DATA_W=4, PRESCALE=20, BLANK=2, DUTY_W=2).
module tb_ssd_scan_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ssd_scan_engine_if #(.NUM_DIGITS(4), .DATA_W(4), .DUTY_W(2)) bus ();

  ssd_scan_engine #(
    .NUM_DIGITS(4), .DATA_W(4), .PRESCALE(20), .BLANK_CYCLES(2), .DUTY_W(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  bright;
    logic [3:0]  en;
    logic        load;
    logic [15:0] data;
    int          exp_low;
    logic [3:0]  exp_ssd;
    logic        exp_fd;
  } row_t;

  row_t rows[10];
  int nvec = 0, nerr = 0;
  int t = 0;
  logic [3:0] obs_ctl, obs_ssd;
  logic [1:0] obs_idx;
  logic       obs_fd;

  // reference model state: frame buffers and per-slot brightness
  logic [3:0] m_act[4], m_pend[4];
  logic       m_pf;
  int         m_b;
  logic [3:0] m_en_prev;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s t=%0d got %0h expected %0h", name, t, got, want);
    end
  endtask

  task automatic model_reset();
    t = 0; m_pf = 1'b0; m_b = 0; m_en_prev = 4'h0;
    for (int k = 0; k < 4; k++) begin
      m_act[k] = 4'h0; m_pend[k] = 4'h0;
    end
  endtask

  task automatic model_step();
    int s, idx;
    logic [3:0] ec;
    s   = t % 20;
    idx = 3 - ((t / 20) % 4);
    if (s == 0) m_b = int'(bus.brightness);
    ec = 4'hF;
    if (s >= 2 && s < 2 + (m_b + 1) * 4 && m_en_prev[idx]) ec[idx] = 1'b0;
    cmp("ctl", 32'(obs_ctl), 32'(ec));
    cmp("ssd_in", 32'(obs_ssd), 32'(m_act[idx]));
    cmp("digit_idx", 32'(obs_idx), 32'(idx));
    cmp("frame_done", 32'(obs_fd), (s == 0 && idx == 3 && t > 0) ? 32'd1 : 32'd0);
    m_en_prev = bus.digit_en;
    if (s == 19 && idx == 0) begin
      if (bus.load) begin
        for (int k = 0; k < 4; k++) m_act[k] = bus.digits_in[k*4 +: 4];
      end else if (m_pf) begin
        for (int k = 0; k < 4; k++) m_act[k] = m_pend[k];
      end
      m_pf = 1'b0;
    end else if (bus.load) begin
      for (int k = 0; k < 4; k++) m_pend[k] = bus.digits_in[k*4 +: 4];
      m_pf = 1'b1;
    end
    t++;
  endtask

  // one clock: sample outputs mid-cycle, check, then move to the next cycle
  task automatic cycle();
    @(negedge clk);
    obs_ctl = bus.ssd_ctl; obs_ssd = bus.ssd_in;
    obs_idx = bus.digit_idx; obs_fd = bus.frame_done;
    model_step();
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  initial begin
    int low, first;
    rows[0] = '{2'd3, 4'hF,    1'b1, 16'h1234, 16, 4'h0, 1'b0};
    rows[1] = '{2'd0, 4'hF,    1'b0, 16'h0000,  4, 4'h0, 1'b0};
    rows[2] = '{2'd3, 4'hF,    1'b0, 16'h0000, 16, 4'h0, 1'b0};
    rows[3] = '{2'd2, 4'hF,    1'b0, 16'h0000, 12, 4'h0, 1'b0};
    rows[4] = '{2'd3, 4'b1011, 1'b0, 16'h0000, 16, 4'h1, 1'b1};
    rows[5] = '{2'd3, 4'b1011, 1'b0, 16'h0000,  0, 4'h2, 1'b0};
    rows[6] = '{2'd3, 4'b1011, 1'b1, 16'hABCD, 16, 4'h3, 1'b0};
    rows[7] = '{2'd2, 4'b0001, 1'b0, 16'h0000, 12, 4'h4, 1'b0};
    rows[8] = '{2'd1, 4'b0111, 1'b0, 16'h0000,  0, 4'hA, 1'b1};
    rows[9] = '{2'd3, 4'hF,    1'b0, 16'h0000, 16, 4'hB, 1'b0};

    rst_n = 1'b0;
    bus.load = 1'b0; bus.digits_in = 16'h0000;
    bus.brightness = rows[0].bright; bus.digit_en = rows[0].en;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    cmp("rst_ctl", 32'(bus.ssd_ctl), 32'hF);
    cmp("rst_ssd_in", 32'(bus.ssd_in), 32'h0);
    cmp("rst_idx", 32'(bus.digit_idx), 32'd3);
    cmp("rst_frame_done", 32'(bus.frame_done), 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    // one table row per slot
    for (int r = 0; r < 10; r++) begin
      low = 0; first = -1;
      for (int s = 0; s < 20; s++) begin
        if (s == 10) begin
          bus.load = rows[r].load; bus.digits_in = rows[r].data;
          if (r < 9) bus.brightness = rows[r+1].bright;
        end
        if (s == 19 && r < 9) bus.digit_en = rows[r+1].en;
        cycle();
        if (s == 0) cmp("tbl_frame_done", 32'(obs_fd), 32'(rows[r].exp_fd));
        if (s == 5) cmp("tbl_ssd_in", 32'(obs_ssd), 32'(rows[r].exp_ssd));
        if (obs_ctl != 4'hF) begin
          low++;
          if (first < 0) first = s;
        end
      end
      cmp("tbl_on_len", 32'(low), 32'(rows[r].exp_low));
      if (rows[r].exp_low > 0) cmp("tbl_on_start", 32'(first), 32'd2);
    end

    // pending load, then a load on the boundary cycle overrides it
    bus.digits_in = 16'h0F0F; bus.load = 1'b1;
    cycle();
    for (int k = 0; k < 80 && (t % 80) != 79; k++) cycle();
    bus.digits_in = 16'h7E57; bus.load = 1'b1;
    cycle();
    cycle();
    cmp("bnd_frame_done", 32'(obs_fd), 32'd1);
    cmp("bnd_ssd_in", 32'(obs_ssd), 32'h7);
    for (int k = 0; k < 79; k++) cycle();
    cycle();
    cmp("bnd_hold_frame_done", 32'(obs_fd), 32'd1);
    cmp("bnd_hold_ssd_in", 32'(obs_ssd), 32'h7);

    // reset at slot cycle 7 of digit 1
    for (int k = 0; k < 80 && (t % 80) != 47; k++) cycle();
    rst_n = 1'b0;
    cycle();
    model_reset();
    rst_n = 1'b1;
    cycle();
    cmp("mid_rst_ctl", 32'(obs_ctl), 32'hF);
    cmp("mid_rst_idx", 32'(obs_idx), 32'd3);
    cmp("mid_rst_ssd_in", 32'(obs_ssd), 32'h0);
    cmp("mid_rst_frame_done", 32'(obs_fd), 32'd0);

    // random traffic; brightness only moves mid-slot
    for (int k = 0; k < 800; k++) begin
      bus.digit_en  = 4'($urandom);
      bus.digits_in = 16'($urandom);
      bus.load      = ($urandom_range(0, 7) == 0);
      if ((t % 20) >= 5 && (t % 20) <= 15 && $urandom_range(0, 5) == 0)
        bus.brightness = 2'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
